// File: rtl/tama_lcd_pkg.sv
// Shared definitions for the LCD draw scheduler: command codes, FSM states and
// the layout of the packed level vector.
package tama_lcd_pkg;

  // Command codes on drv_sel; also used as bit positions of the pending vector.
  typedef enum logic [1:0] {
    SelInit = 2'd0,
    SelFace = 2'd1,
    SelBars = 2'd2,
    SelFull = 2'd3
  } drv_sel_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StGap   = 2'd3
  } state_e;

  localparam int unsigned FaceW   = 4;
  localparam int unsigned LevelW  = 3;
  localparam int unsigned LevelsW = 5 * LevelW;

  // Field offsets inside levels: {food, sleep, fun, happy, health}.
  localparam int unsigned HealthLsb = 0;
  localparam int unsigned HappyLsb  = 3;
  localparam int unsigned FunLsb    = 6;
  localparam int unsigned SleepLsb  = 9;
  localparam int unsigned FoodLsb   = 12;

  // Fixed priority: INIT > FULL > FACE > BARS.
  function automatic drv_sel_e pick_cmd(input logic [3:0] pend);
    if (pend[SelInit]) return SelInit;
    if (pend[SelFull]) return SelFull;
    if (pend[SelFace]) return SelFace;
    return SelBars;
  endfunction

endpackage

// File: rtl/lcd_draw_scheduler_if.sv
// Command/completion handshake between the draw scheduler and the SPI LCD driver.
interface lcd_draw_scheduler_if;
  import tama_lcd_pkg::*;

  logic               drv_start;
  logic [1:0]         drv_sel;
  logic [FaceW-1:0]   drv_face;
  logic [LevelsW-1:0] drv_levels;
  logic               drv_done;

  modport master (
    output drv_start, drv_sel, drv_face, drv_levels,
    input  drv_done
  );

  modport slave (
    input  drv_start, drv_sel, drv_face, drv_levels,
    output drv_done
  );
endinterface

// File: rtl/lcd_refresh_timer.sv
// Free-running refresh counter: pulses wrap once every PERIOD cycles.
// A synchronous clear restarts the period and suppresses a coincident wrap.
module lcd_refresh_timer #(
  parameter int unsigned PERIOD = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic wrap
);
  localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_end;

  assign at_end = (cnt_q == CntW'(PERIOD - 1));
  assign wrap   = at_end && !clr;

  // Count up, restarting at the end of the period or on clear.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || at_end) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/lcd_draw_scheduler.sv
// Draw scheduler: collects redraw requests as pending flags and issues them to
// the LCD driver one at a time, waiting for completion and keeping a minimum gap.
module lcd_draw_scheduler
  import tama_lcd_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned MIN_GAP        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 face_req,
  input  logic [FaceW-1:0]     face_in,
  input  logic [LevelsW-1:0]   levels_in,
  lcd_draw_scheduler_if.master drv,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam int unsigned CntMax = (TIMEOUT_CYCLES > MIN_GAP) ? TIMEOUT_CYCLES : MIN_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [3:0]         pend_q, pend_d;
  drv_sel_e           cmd_q, cmd_d;
  logic [FaceW-1:0]   face_q, face_d;
  logic [FaceW-1:0]   drv_face_q, drv_face_d;
  logic [LevelsW-1:0] last_levels_q, last_levels_d;
  logic [LevelsW-1:0] drv_levels_q, drv_levels_d;
  logic               timeout_err_q, timeout_err_d;
  logic               issuing, levels_cmd, refresh_wrap, refresh_clr;

  assign issuing     = (state_q == StIssue);
  assign levels_cmd  = (cmd_q == SelBars) || (cmd_q == SelFull);
  assign refresh_clr = issuing && (cmd_q == SelFull);

  lcd_refresh_timer #(
    .PERIOD(REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk (clk),
    .rst (rst),
    .clr (refresh_clr),
    .wrap(refresh_wrap)
  );

  // Next-state logic: command sequencing, then request capture.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    cmd_d         = cmd_q;
    face_d        = face_q;
    drv_face_d    = drv_face_q;
    drv_levels_d  = drv_levels_q;
    last_levels_d = last_levels_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          cmd_d   = pick_cmd(pend_q);
          state_d = StIssue;
        end
      end
      StIssue: begin
        pend_d[cmd_q] = 1'b0;
        // A full redraw already covers face and bars.
        if (cmd_q == SelFull) begin
          pend_d[SelFace] = 1'b0;
          pend_d[SelBars] = 1'b0;
        end
        if (levels_cmd) last_levels_d = levels_in;
        drv_face_d   = face_q;
        drv_levels_d = levels_in;
        cnt_d        = '0;
        state_d      = StWait;
      end
      StWait: begin
        if (drv.drv_done) begin
          cnt_d   = '0;
          state_d = StGap;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          pend_d[cmd_q] = 1'b1;
          cnt_d         = '0;
          state_d       = StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(MIN_GAP - 1)) state_d = StIdle;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Captured after the clears so a same-cycle new request is never dropped.
    if (face_req) begin
      face_d          = face_in;
      pend_d[SelFace] = 1'b1;
    end
    if (!(issuing && levels_cmd) && (levels_in != last_levels_q)) pend_d[SelBars] = 1'b1;
    if (refresh_wrap) pend_d[SelFull] = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      pend_q        <= 4'b0001;  // only INIT pending out of reset
      cmd_q         <= SelInit;
      face_q        <= '0;
      drv_face_q    <= '0;
      drv_levels_q  <= '0;
      last_levels_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      cmd_q         <= cmd_d;
      face_q        <= face_d;
      drv_face_q    <= drv_face_d;
      drv_levels_q  <= drv_levels_d;
      last_levels_q <= last_levels_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // During ISSUE the live values go out; afterwards the registered copies hold.
  assign drv.drv_start  = issuing;
  assign drv.drv_sel    = cmd_q;
  assign drv.drv_face   = issuing ? face_q : drv_face_q;
  assign drv.drv_levels = issuing ? levels_in : drv_levels_q;
  assign busy           = (state_q != StIdle);
  assign timeout_err    = timeout_err_q;
endmodule

// File: tb/tb_lcd_draw_scheduler.sv
// Bench for lcd_draw_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a timestamp-based reference model.
module tb_lcd_draw_scheduler;
  import tama_lcd_pkg::*;

  localparam int unsigned R = 1000;
  localparam int unsigned T = 100;
  localparam int unsigned G = 4;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        face_req  = 1'b0;
  logic [3:0]  face_in   = '0;
  logic [14:0] levels_in = '0;
  logic        busy;
  logic        timeout_err;

  lcd_draw_scheduler_if drv_bus ();

  lcd_draw_scheduler #(
    .REFRESH_CYCLES(R),
    .TIMEOUT_CYCLES(T),
    .MIN_GAP       (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .face_req   (face_req),
    .face_in    (face_in),
    .levels_in  (levels_in),
    .drv        (drv_bus),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: pending requests as a set of booleans, time kept as cycle stamps.
  bit          m_pend[4];
  logic [3:0]  m_face;
  logic [14:0] m_last_lv;
  int          m_ref_base;
  bit          m_terr;
  bit          m_issue_pending;
  int          m_issue_cyc;
  int          m_cmd;
  bit          m_waiting;
  int          m_wait_start;
  int          m_free_cyc;
  int          m_hold_sel;
  logic [3:0]  m_hold_face;
  logic [14:0] m_hold_lv;

  // Driver responder and command monitor.
  int          resp_lat = 10;
  int          done_at  = -1;
  bit          spur_en  = 1'b0;
  int          cnt_sel[4];
  int          base_sel[4];
  int          last_start_cyc = -1;
  logic [3:0]  last_face_cmd;
  logic [14:0] last_bars_lv;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    m_pend[0]       = 1'b1;
    m_face          = '0;
    m_last_lv       = '0;
    m_ref_base      = cyc + 1;
    m_terr          = 1'b0;
    m_issue_pending = 1'b0;
    m_waiting       = 1'b0;
    m_free_cyc      = 0;
    m_hold_sel      = 0;
    m_hold_face     = '0;
    m_hold_lv       = '0;
    done_at         = -1;
  endtask

  task automatic model_step();
    int          n = cyc;
    bit          issue_now;
    bit          full_now = 1'b0;
    bit          picked = 1'b0;
    int          order[4] = '{0, 3, 1, 2};
    int          e_sel;
    logic [3:0]  e_face;
    logic [14:0] e_lv;
    bit          e_busy;

    issue_now = m_issue_pending && (m_issue_cyc == n);
    e_busy    = issue_now || m_waiting || (n < m_free_cyc);
    if (issue_now) begin
      e_sel = m_cmd; e_face = m_face; e_lv = levels_in;
    end else begin
      e_sel = m_hold_sel; e_face = m_hold_face; e_lv = m_hold_lv;
    end
    check_eq("drv_start", 32'(drv_bus.drv_start), 32'(issue_now));
    check_eq("drv_sel", 32'(drv_bus.drv_sel), 32'(e_sel));
    check_eq("drv_face", 32'(drv_bus.drv_face), 32'(e_face));
    check_eq("drv_levels", 32'(drv_bus.drv_levels), 32'(e_lv));
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("timeout_err", 32'(timeout_err), 32'(m_terr));

    if (issue_now) begin
      m_pend[m_cmd] = 1'b0;
      if (m_cmd == 3) begin
        m_pend[1] = 1'b0;
        m_pend[2] = 1'b0;
        full_now  = 1'b1;
      end
      if (m_cmd >= 2) m_last_lv = levels_in;
      m_hold_sel      = m_cmd;
      m_hold_face     = m_face;
      m_hold_lv       = levels_in;
      m_issue_pending = 1'b0;
      m_waiting       = 1'b1;
      m_wait_start    = n + 1;
    end else if (m_waiting) begin
      if (drv_bus.drv_done) begin
        m_waiting  = 1'b0;
        m_free_cyc = n + 1 + G;
      end else if (n - m_wait_start == T - 1) begin
        m_terr        = 1'b1;
        m_pend[m_cmd] = 1'b1;
        m_waiting     = 1'b0;
        m_free_cyc    = n + 1 + G;
      end
    end else if (!m_issue_pending && n >= m_free_cyc) begin
      for (int i = 0; i < 4; i++) begin
        if (!picked && m_pend[order[i]]) begin
          m_cmd           = order[i];
          picked          = 1'b1;
          m_issue_pending = 1'b1;
          m_issue_cyc     = n + 1;
        end
      end
    end

    if (face_req) begin
      m_pend[1] = 1'b1;
      m_face    = face_in;
    end
    if (!(issue_now && m_cmd >= 2) && levels_in != m_last_lv) m_pend[2] = 1'b1;
    if (full_now) m_ref_base = n + 1;
    else if (n - m_ref_base == R - 1) begin
      m_pend[3]  = 1'b1;
      m_ref_base = n + 1;
    end
  endtask

  // Per-cycle checking on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check_eq("rst_drv_start", 32'(drv_bus.drv_start), 32'd0);
      check_eq("rst_drv_sel", 32'(drv_bus.drv_sel), 32'd0);
      check_eq("rst_drv_face", 32'(drv_bus.drv_face), 32'd0);
      check_eq("rst_drv_levels", 32'(drv_bus.drv_levels), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
      model_reset();
    end else begin
      model_step();
      if (drv_bus.drv_start) begin
        done_at = (resp_lat == 0) ? -1 : cyc + resp_lat;
        cnt_sel[drv_bus.drv_sel]++;
        last_start_cyc = cyc;
        if (drv_bus.drv_sel == 2'd1) last_face_cmd = drv_bus.drv_face;
        if (drv_bus.drv_sel == 2'd2) last_bars_lv = drv_bus.drv_levels;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    face_req = 1'b0;
    drv_bus.drv_done = (done_at >= 0 && cyc == done_at) ||
                       (spur_en && $urandom_range(0, 31) == 0);
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  task automatic snap();
    for (int i = 0; i < 4; i++) base_sel[i] = cnt_sel[i];
  endtask

  task automatic request_face(input logic [3:0] v);
    face_req = 1'b1;
    face_in  = v;
  endtask

  int rel_cyc;
  bit found;
  int lsb_tab[5] = '{HealthLsb, HappyLsb, FunLsb, SleepLsb, FoodLsb};
  logic [14:0] lv_new;

  initial begin
    drv_bus.drv_done = 1'b0;
    for (int i = 0; i < 4; i++) cnt_sel[i] = 0;

    // Reset release -> INIT within two cycles, then done after 10 cycles.
    idle(3);
    tick();
    rst     = 1'b0;
    rel_cyc = cyc;
    snap();
    idle(30);
    check_eq("init_count", 32'(cnt_sel[0] - base_sel[0]), 32'd1);
    check_eq("init_within_2", 32'(last_start_cyc - rel_cyc <= 2), 32'd1);

    // Two face requests, the second during WAIT: one more FACE with the newest code.
    snap();
    tick(); request_face(4'd5);
    idle(4);
    tick(); request_face(4'd9);
    idle(40);
    check_eq("coalesce_face_count", 32'(cnt_sel[1] - base_sel[1]), 32'd2);
    check_eq("coalesce_face_code", 32'(last_face_cmd), 32'd9);

    // Face request and level change together: FACE then BARS with the new levels.
    snap();
    lv_new = 15'h1a2b;
    tick(); request_face(4'd3); levels_in = lv_new;
    idle(60);
    check_eq("face_bars_face_count", 32'(cnt_sel[1] - base_sel[1]), 32'd1);
    check_eq("face_bars_bars_count", 32'(cnt_sel[2] - base_sel[2]), 32'd1);
    check_eq("face_bars_levels", 32'(last_bars_lv), 32'(lv_new));

    // Silent driver: timeout, then the same command is reissued.
    snap();
    resp_lat = 0;
    done_at  = -1;
    tick(); request_face(4'd7);
    idle(99);
    resp_lat = 10;
    idle(60);
    check_eq("timeout_flag", 32'(timeout_err), 32'd1);
    check_eq("timeout_reissue_count", 32'(cnt_sel[1] - base_sel[1]), 32'd2);
    check_eq("timeout_reissue_code", 32'(last_face_cmd), 32'd7);

    // Refresh wrap coinciding with face and level requests: only FULL is issued.
    found = 1'b0;
    for (int i = 0; i < 1200 && !found; i++) begin
      tick();
      if (cyc - m_ref_base == R - 1) begin
        found = 1'b1;
        snap();
        request_face(4'd11);
        levels_in = levels_in ^ 15'h0421;
      end
    end
    check_eq("refresh_reached", 32'(found), 32'd1);
    idle(40);
    check_eq("full_count", 32'(cnt_sel[3] - base_sel[3]), 32'd1);
    check_eq("full_no_face", 32'(cnt_sel[1] - base_sel[1]), 32'd0);
    check_eq("full_no_bars", 32'(cnt_sel[2] - base_sel[2]), 32'd0);

    // Reset pulse while waiting on the driver: INIT comes next.
    tick(); request_face(4'd2);
    idle(5);
    tick(); rst = 1'b1;
    idle(2);
    tick(); rst = 1'b0;
    snap();
    idle(30);
    check_eq("rst_wait_init_count", 32'(cnt_sel[0] - base_sel[0]), 32'd1);

    // Randomized traffic with spurious completions and occasional silent driver.
    spur_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (i == 2000) begin
        rst = 1'b1;
        idle(2);
        tick();
        rst = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) request_face(4'($urandom));
      if ($urandom_range(0, 19) == 0)
        levels_in[lsb_tab[$urandom_range(0, 4)] +: LevelW] = 3'($urandom);
      if ($urandom_range(0, 49) == 0)
        resp_lat = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 25));
    end
    spur_en = 1'b0;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
